regfile_mp: RTL and testbench

- Parametrised multi-port register file for the single-cycle core, with optional extra read ports for debug.
- Adds the following over the base file:
  - N combinational read ports
  - two write ports with byte enables and fixed priority
  - a hardwired zero register
  - optional write-to-read bypass
  - asynchronous reset clear
  - a sequential soft-clear engine that sweeps all registers to zero
- Sits between decode (read addresses) and writeback (write ports).

---
 rtl/regfile_pkg.sv | 32 +++
 rtl/regfile_clr_fsm.sv | 68 ++++++
 rtl/regfile_mp.sv | 136 +++++++++++++
 tb/tb_regfile_mp.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

    // Widest word the byte-merge helper handles. Callers zero-extend into it.
    localparam int MAX_DATA_W = 256;
    localparam int MAX_BE_W   = MAX_DATA_W / 8;

    // States of the soft-clear engine.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    // Replace each byte of old_word whose enable is set with the same byte of
    // new_word. The write path and the bypass path both use this, so what is
    // stored and what is forwarded cannot drift apart.
    function automatic logic [MAX_DATA_W-1:0] merge_bytes(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_word,
        input logic [MAX_BE_W-1:0]   be
    );
        logic [MAX_DATA_W-1:0] result;
        result = old_word;
        for (int b = 0; b < MAX_BE_W; b++) begin
            if (be[b]) begin
                result[b*8 +: 8] = new_word[b*8 +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/regfile_clr_fsm.sv
// Soft-clear engine: sweeps every register address once and writes zero to it.
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    clr_state_t        state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;

    // State and sweep-counter registers.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the edge, regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic and the clear-write controls.
    // NOTE: every output of this block is given a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clr_busy  = 1'b0;
        clr_done  = 1'b0;
        clr_we    = 1'b0;
        clr_addr  = cnt;
        case (state)
            ST_IDLE: begin
                if (clr_req) begin
                    state_nxt = ST_CLEAR;
                    cnt_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                clr_busy = 1'b1;
                clr_we   = 1'b1;
                cnt_nxt  = cnt + ADDR_W'(1);
                if (cnt == LAST_ADDR) begin
                    clr_done  = 1'b1;
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: N combinational read ports, two byte-enabled
// write ports (port 1 wins overlapping bytes), optional hardwired zero
// register, optional write-to-read bypass and a sequential soft clear.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [NRD*ADDR_W-1:0] RA,
    output logic [NRD*DATA_W-1:0] RD,
    input  logic                  WE0,
    input  logic [ADDR_W-1:0]     WA0,
    input  logic [DATA_W-1:0]     WD0,
    input  logic [DATA_W/8-1:0]   WBE0,
    input  logic                  WE1,
    input  logic [ADDR_W-1:0]     WA1,
    input  logic [DATA_W-1:0]     WD1,
    input  logic [DATA_W/8-1:0]   WBE1,
    input  logic                  CLR_REQ,
    output logic                  CLR_BUSY,
    output logic                  CLR_DONE
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int BE_W  = DATA_W / 8;

    // Reject parameter sets the read muxes and byte lanes cannot support.
    generate
        if (NRD < 1 || NRD > 4 || (DATA_W % 8) != 0 || DATA_W > MAX_DATA_W) begin : g_bad_params
            $error("regfile_mp: unsupported NRD or DATA_W");
        end
    endgenerate

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              we0_eff, we1_eff;
    logic [DATA_W-1:0] post0, post1;

    // Narrow wrapper around the shared merge helper.
    function automatic logic [DATA_W-1:0] merge_word(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [BE_W-1:0]   be
    );
        return DATA_W'(merge_bytes(MAX_DATA_W'(old_word), MAX_DATA_W'(new_word), MAX_BE_W'(be)));
    endfunction

    // Post-edge value of a word given which write ports hit it; port 1 is
    // applied last so it owns bytes enabled on both ports.
    function automatic logic [DATA_W-1:0] apply_writes(
        input logic [DATA_W-1:0] old_word,
        input logic              hit0,
        input logic              hit1,
        input logic [DATA_W-1:0] d0,
        input logic [BE_W-1:0]   be0,
        input logic [DATA_W-1:0] d1,
        input logic [BE_W-1:0]   be1
    );
        logic [DATA_W-1:0] w;
        w = old_word;
        if (hit0) w = merge_word(w, d0, be0);
        if (hit1) w = merge_word(w, d1, be1);
        return w;
    endfunction

    regfile_clr_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clr_fsm (
        .clk      (CLK),
        .rst_n    (RST_N),
        .clr_req  (CLR_REQ),
        .clr_busy (CLR_BUSY),
        .clr_done (CLR_DONE),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Qualified write enables: blocked during a sweep and, with a hardwired
    // zero register, for address 0.
    always_comb begin
        we0_eff = WE0 && !CLR_BUSY && !((ZERO_REG != 0) && (WA0 == '0));
        we1_eff = WE1 && !CLR_BUSY && !((ZERO_REG != 0) && (WA1 == '0));
    end

    // Merged post-edge values at both write addresses; on a collision both
    // carry the same fully merged word.
    always_comb begin
        post0 = apply_writes(mem[WA0], we0_eff, we1_eff && (WA1 == WA0), WD0, WBE0, WD1, WBE1);
        post1 = apply_writes(mem[WA1], we0_eff && (WA0 == WA1), we1_eff, WD0, WBE0, WD1, WBE1);
    end

    // Register array: async clear on reset, sweep writes while clearing,
    // otherwise the two merged write ports.
    // NOTE: the array is reset explicitly because an async clear of every
    // register is part of this block's behaviour; this keeps it in flops.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr_we) begin
            mem[clr_addr] <= '0;
        end else begin
            if (we0_eff) mem[WA0] <= post0;
            if (we1_eff) mem[WA1] <= post1;
        end
    end

    // Combinational read muxes with optional bypass and zero-register masking.
    always_comb begin
        RD = '0;
        for (int i = 0; i < NRD; i++) begin
            logic [ADDR_W-1:0] ra;
            logic [DATA_W-1:0] data;
            ra   = RA[i*ADDR_W +: ADDR_W];
            data = mem[ra];
            if (BYPASS != 0) begin
                data = apply_writes(data, we0_eff && (WA0 == ra), we1_eff && (WA1 == ra),
                                    WD0, WBE0, WD1, WBE1);
            end
            if ((ZERO_REG != 0) && (ra == '0)) begin
                data = '0;
            end
            RD[i*DATA_W +: DATA_W] = data;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: table-driven read/write vectors plus
// hand-written soft-clear and reset-during-clear sequences.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  ra0, ra1;
    logic [63:0] rd, rd_nb;
    logic        we0, we1;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [3:0]  wbe0, wbe1;
    logic        clr_req;
    logic        busy, done, busy_nb, done_nb;

    int checks = 0;
    int errors = 0;
    int done_total = 0;

    typedef struct {
        logic        we0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [3:0]  wbe0;
        logic        we1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [3:0]  wbe1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] exp_rd0;
        logic [31:0] exp_rd1;
        logic [31:0] exp_nb_rd0;
    } vec_t;

    vec_t vecs [15];

    regfile_mp dut (
        .CLK(clk), .RST_N(rst_n), .RA({ra1, ra0}), .RD(rd),
        .WE0(we0), .WA0(wa0), .WD0(wd0), .WBE0(wbe0),
        .WE1(we1), .WA1(wa1), .WD1(wd1), .WBE1(wbe1),
        .CLR_REQ(clr_req), .CLR_BUSY(busy), .CLR_DONE(done)
    );

    regfile_mp #(.BYPASS(0)) dut_nb (
        .CLK(clk), .RST_N(rst_n), .RA({ra1, ra0}), .RD(rd_nb),
        .WE0(we0), .WA0(wa0), .WD0(wd0), .WBE0(wbe0),
        .WE1(we1), .WA1(wa1), .WD1(wd1), .WBE1(wbe1),
        .CLR_REQ(clr_req), .CLR_BUSY(busy_nb), .CLR_DONE(done_nb)
    );

    always #5 clk = ~clk;

    // Count CLR_DONE pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (done) done_total++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        we0 = 0; wa0 = 0; wd0 = 0; wbe0 = 0;
        we1 = 0; wa1 = 0; wd1 = 0; wbe1 = 0;
        clr_req = 0;
    endtask

    // Single full-word write through port 0, one cycle.
    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        we0 = 1; wa0 = a; wd0 = d; wbe0 = 4'hF;
        @(negedge clk);
        we0 = 0;
    endtask

    task automatic fill_regs();
        for (int r = 1; r < 32; r++) begin
            write_reg(5'(r), 32'(r) * 32'h0101_0101);
        end
    endtask

    // Number of registers that read back nonzero on port 0 (no writes active).
    task automatic scan_nonzero(output int n);
        n = 0;
        for (int a = 0; a < 32; a++) begin
            ra0 = 5'(a);
            #1;
            if (rd[31:0] != 32'h0) n++;
        end
    endtask

    // Pulse CLR_REQ and follow the sweep, counting busy cycles and done pulses.
    // With inject set, a port-0 write to reg 9 is attempted on busy cycle 20.
    task automatic run_clear(input bit inject, output int busy_cycles,
                             output int done_count, output int done_at);
        busy_cycles = 0;
        done_count  = 0;
        done_at     = -1;
        @(negedge clk);
        clr_req = 1;
        @(negedge clk);
        clr_req = 0;
        for (int c = 0; c < 40; c++) begin
            if (!busy) break;
            busy_cycles++;
            if (done) begin
                done_count++;
                done_at = busy_cycles;
            end
            if (inject && busy_cycles == 20) begin
                we0 = 1; wa0 = 5'd9; wd0 = 32'hFFFF_FFFF; wbe0 = 4'hF; ra0 = 5'd9;
                #1;
                check("clear_write_no_bypass", rd[31:0], 32'h0);
            end
            @(negedge clk);
            we0 = 0;
        end
    endtask

    initial begin
        int bc, dc, da, nz, done_before;

        //            we0 wa0   wd0            wbe0  we1 wa1   wd1            wbe1  ra0   ra1   rd0            rd1            nb_rd0
        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 4'hF, 1'b0, 5'd0,  32'h0,        4'h0, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        32'h0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        4'h0, 1'b0, 5'd0,  32'h0,        4'h0, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 5'd5,  32'h0000AA00, 4'h2, 1'b0, 5'd0,  32'h0,        4'h0, 5'd5,  5'd6,  32'hDEADAAEF, 32'h0,        32'hDEADBEEF};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        4'h0, 1'b0, 5'd0,  32'h0,        4'h0, 5'd5,  5'd6,  32'hDEADAAEF, 32'h0,        32'hDEADAAEF};
        vecs[4]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 4'hF, 1'b0, 5'd0,  32'h0,        4'h0, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,        4'h0, 1'b0, 5'd0,  32'h0,        4'h0, 5'd0,  5'd5,  32'h0,        32'hDEADAAEF, 32'h0};
        vecs[6]  = '{1'b1, 5'd7,  32'h11111111, 4'hF, 1'b1, 5'd7,  32'h22222222, 4'h3, 5'd5,  5'd7,  32'hDEADAAEF, 32'h11112222, 32'hDEADAAEF};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,        4'h0, 1'b0, 5'd0,  32'h0,        4'h0, 5'd7,  5'd7,  32'h11112222, 32'h11112222, 32'h11112222};
        vecs[8]  = '{1'b1, 5'd8,  32'h12345678, 4'h0, 1'b1, 5'd9,  32'hAABBCCDD, 4'hC, 5'd8,  5'd9,  32'h0,        32'hAABB0000, 32'h0};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        4'h0, 1'b0, 5'd0,  32'h0,        4'h0, 5'd8,  5'd9,  32'h0,        32'hAABB0000, 32'h0};
        vecs[10] = '{1'b1, 5'd10, 32'h000000EE, 4'h1, 1'b1, 5'd10, 32'hDD000000, 4'h8, 5'd10, 5'd9,  32'hDD0000EE, 32'hAABB0000, 32'h0};
        vecs[11] = '{1'b0, 5'd0,  32'h0,        4'h0, 1'b0, 5'd0,  32'h0,        4'h0, 5'd10, 5'd10, 32'hDD0000EE, 32'hDD0000EE, 32'hDD0000EE};
        vecs[12] = '{1'b1, 5'd3,  32'h00000001, 4'hF, 1'b0, 5'd0,  32'h0,        4'h0, 5'd3,  5'd3,  32'h1,        32'h1,        32'h0};
        vecs[13] = '{1'b1, 5'd3,  32'h00000055, 4'hF, 1'b0, 5'd0,  32'h0,        4'h0, 5'd3,  5'd3,  32'h55,       32'h55,       32'h1};
        vecs[14] = '{1'b0, 5'd0,  32'h0,        4'h0, 1'b0, 5'd0,  32'h0,        4'h0, 5'd3,  5'd3,  32'h55,       32'h55,       32'h55};

        // Reset state.
        rst_n = 0;
        idle_inputs();
        ra0 = 5'd5; ra1 = 5'd7;
        #12;
        check("reset_rd0", rd[31:0], 32'h0);
        check("reset_rd1", rd[63:32], 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        @(negedge clk);
        rst_n = 1;

        // Table-driven read/write vectors: drive at negedge, check before the edge.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            we0 = vecs[i].we0; wa0 = vecs[i].wa0; wd0 = vecs[i].wd0; wbe0 = vecs[i].wbe0;
            we1 = vecs[i].we1; wa1 = vecs[i].wa1; wd1 = vecs[i].wd1; wbe1 = vecs[i].wbe1;
            ra0 = vecs[i].ra0; ra1 = vecs[i].ra1;
            #2;
            check($sformatf("vec%0d_rd0", i), rd[31:0], vecs[i].exp_rd0);
            check($sformatf("vec%0d_rd1", i), rd[63:32], vecs[i].exp_rd1);
            check($sformatf("vec%0d_nb_rd0", i), rd_nb[31:0], vecs[i].exp_nb_rd0);
        end
        @(negedge clk);
        idle_inputs();

        // Soft clear with a blocked write mid-sweep.
        fill_regs();
        ra0 = 5'd31; ra1 = 5'd9;
        #1;
        check("fill_reg31", rd[31:0], 32'h1F1F_1F1F);
        check("fill_reg9", rd[63:32], 32'h0909_0909);
        run_clear(1'b1, bc, dc, da);
        check("clear_busy_cycles", 32'(bc), 32'd32);
        check("clear_done_count", 32'(dc), 32'd1);
        check("clear_done_cycle", 32'(da), 32'd32);
        check("clear_busy_low_after", 32'(busy), 32'h0);
        scan_nonzero(nz);
        check("clear_all_zero", 32'(nz), 32'h0);

        // Reset asserted partway through a sweep.
        fill_regs();
        done_before = done_total;
        @(negedge clk);
        clr_req = 1;
        @(negedge clk);
        clr_req = 0;
        repeat (9) @(negedge clk);
        check("midclear_busy_before_reset", 32'(busy), 32'h1);
        ra0 = 5'd31; ra1 = 5'd20;
        #1;
        check("midclear_reg31_uncleared", rd[31:0], 32'h1F1F_1F1F);
        #1;
        rst_n = 0;
        #1;
        check("midreset_busy", 32'(busy), 32'h0);
        check("midreset_done", 32'(done), 32'h0);
        check("midreset_reg31", rd[31:0], 32'h0);
        check("midreset_reg20", rd[63:32], 32'h0);
        @(negedge clk);
        rst_n = 1;
        check("midreset_no_done_pulse", 32'(done_total - done_before), 32'h0);
        scan_nonzero(nz);
        check("midreset_all_zero", 32'(nz), 32'h0);

        // A fresh sweep after reset runs to completion.
        write_reg(5'd12, 32'hCAFE_F00D);
        run_clear(1'b0, bc, dc, da);
        check("reclear_busy_cycles", 32'(bc), 32'd32);
        check("reclear_done_count", 32'(dc), 32'd1);
        check("reclear_done_cycle", 32'(da), 32'd32);
        scan_nonzero(nz);
        check("reclear_all_zero", 32'(nz), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
